apb_bus_arbiter: RTL and testbench
==================================

// Module: apb_bus_arbiter
// PURPOSE
//   Round-robin arbiter and APB3 master sequencer sharing one APB bus (bank-select style) between
//   REQ_NUM requesters, e.g. spi2apb_bridge plus a local config/GPIO sequencer. Grants one request,
//   drives a SETUP/ACCESS transfer, honours b_pready with an optional timeout, returns data/status.
// PARAMETERS
//   REQ_NUM     2   number of requesters (>=2)
//   BANK_NUM    2   number of APB slaves; width of one-hot b_psel
//   BANK_IDX_W  1   width of per-request bank index
//   DATA_WIDTH  8   APB data width
//   ADDR_WIDTH  3   APB address width
//   TIMEOUT     16  max ACCESS cycles waiting for b_pready; 0 = wait forever
// PORTS
//   clk        in   1                     bus clock; all logic on rising edge
//   resetn     in   1                     asynchronous active-low reset
//   req_valid  in   REQ_NUM               request pending, held until own req_done
//   req_write  in   REQ_NUM               1 = write, 0 = read
//   req_bank   in   REQ_NUM*BANK_IDX_W    bank index, requester i in slice i
//   req_addr   in   REQ_NUM*ADDR_WIDTH    register address, slice i
//   req_wdata  in   REQ_NUM*DATA_WIDTH    write data, slice i
//   req_gnt    out  REQ_NUM               one-hot grant, SETUP through DONE
//   req_done   out  REQ_NUM               one-cycle completion pulse to granted requester
//   req_err    out  1                     valid with req_done: timeout or bad bank
//   rsp_rdata  out  DATA_WIDTH            read data, valid with req_done
//   b_psel     out  BANK_NUM              one-hot APB select
//   b_penable  out  1                     APB enable
//   b_pwrite   out  1                     APB direction
//   b_paddr    out  ADDR_WIDTH            APB address
//   b_pwdata   out  DATA_WIDTH            APB write data
//   b_pready   in   1                     slave ready
//   b_prdata   in   DATA_WIDTH            slave read data
// BEHAVIOUR
//   Reset: async, all outputs 0, FSM IDLE, rr pointer last=REQ_NUM-1 (req 0 highest first).
//   Reset mid-transfer: bus dropped immediately, no req_done issued.
//   FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE; IDLE -> DONE directly on bad bank.
//   IDLE: if any req_valid, pick first valid scanning from (last+1) mod REQ_NUM upward with wrap;
//     latch its write/bank/addr/wdata into regs, set req_gnt, update last. No valid: stay.
//     Bank index >= BANK_NUM: no APB cycle, go DONE with req_err=1, rsp_rdata=0.
//   SETUP (1 cycle): b_psel[bank]=1, b_penable=0, b_pwrite/b_paddr/b_pwdata from latched regs.
//   ACCESS: b_penable=1, psel/addr/data/write held stable; timeout counter counts ACCESS cycles.
//     b_pready=1 at edge -> capture b_prdata (reads; writes give 0) -> DONE, req_err=0.
//     Counter reaches TIMEOUT without pready -> DONE, req_err=1, rsp_rdata=0.
//     pready and timeout on same edge: pready wins, no error.
//   DONE (1 cycle): psel/penable=0, req_done[gnt]=1, req_err/rsp_rdata valid; then IDLE, gnt cleared.
//     Requester must drop or change req_valid during DONE; IDLE re-samples next cycle.
//   Latency, zero-wait slave: valid seen edge 0 -> SETUP; edge1 ACCESS; edge2 DONE (done high);
//     edge3 IDLE. Min 4 cycles per transfer, one IDLE cycle between transfers.
//   Request inputs only sampled in IDLE; changes while granted are ignored.
//   rsp_rdata/req_err hold value until next DONE; req_done strictly one cycle.
//   Fairness: with all requesters permanently valid, grants rotate 0,1,...,REQ_NUM-1,0.
// TESTING
//   1 Req0 write bank1 addr 5 data A5, pready tied 1 -> psel=2'b10 SETUP 1 cyc, ACCESS 1 cyc,
//     pwdata=A5, done[0] 3rd cycle after valid, err=0.
//   2 Req1 read bank0 addr 3, pready low 3 ACCESS cycles, prdata=3C -> penable 4 cyc, rsp_rdata=3C.
//   3 Req0,req1 valid continuously, zero-wait -> grants alternate 0,1,0,1; no back-to-back same id.
//   4 TIMEOUT=16, pready never -> 16 ACCESS cycles, then done with err=1, rsp_rdata=0, bus idle.
//   5 Req0 bank index 1 with BANK_NUM=1 -> no psel ever, done[0] with err=1 next cycle.
//   6 resetn low during ACCESS -> psel/penable/gnt 0 same cycle, no done; req1 then granted
//     after reset (req1 only valid).

Source files
------------

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: round-robin arbiter in front of a single APB3 master.
// One requester at a time is granted. Its request is latched, and a
// SETUP/ACCESS transfer is run on the selected bank. The data and status
// are then returned with a one-cycle req_done pulse.
//
// Handshake: a requester raises req_valid and holds it, with stable
// write/bank/addr/wdata, until its own req_done pulse. It must drop or change
// req_valid while req_done is high. Request inputs are only sampled in IDLE.
// APB side: psel/paddr/pwrite/pwdata are stable from SETUP through ACCESS.
// A transfer completes on the first ACCESS edge that sees b_pready=1.
module apb_bus_arbiter #(
  parameter int REQ_NUM    = 2,
  parameter int BANK_NUM   = 2,
  parameter int BANK_IDX_W = 1,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [REQ_NUM-1:0]             req_valid,
  input  logic [REQ_NUM-1:0]             req_write,
  input  logic [REQ_NUM*BANK_IDX_W-1:0]  req_bank,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]  req_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]  req_wdata,
  output logic [REQ_NUM-1:0]             req_gnt,
  output logic [REQ_NUM-1:0]             req_done,
  output logic                           req_err,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic [BANK_NUM-1:0]            b_psel,
  output logic                           b_penable,
  output logic                           b_pwrite,
  output logic [ADDR_WIDTH-1:0]          b_paddr,
  output logic [DATA_WIDTH-1:0]          b_pwdata,
  input  logic                           b_pready,
  input  logic [DATA_WIDTH-1:0]          b_prdata,
  output logic [1:0]                     dbg_state
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [REQ_NUM-1:0]      gnt_q, gnt_d;
  logic [REQ_NUM-1:0]      done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [BANK_NUM-1:0]     psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Round-robin pick: the first valid request after the last granted one.
  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic [REQ_NUM-1:0]      sel_oh;
  int                      scan_pos;

  logic                    sel_write;
  logic [BANK_IDX_W-1:0]   sel_bank;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_bad;
  logic [BANK_NUM-1:0]     sel_psel;
  logic                    timeout_hit;

  // Scan requesters starting at (last+1) mod REQ_NUM, wrapping around once.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    scan_pos  = 0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      scan_pos = (int'(last_q) + k) % REQ_NUM;
      if (!sel_found && req_valid[scan_pos]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(scan_pos);
      end
    end
    sel_oh[sel_idx] = sel_found;
  end

  assign sel_write = req_write[sel_idx];
  assign sel_bank  = req_bank[sel_idx*BANK_IDX_W +: BANK_IDX_W];
  assign sel_addr  = req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_bad   = (int'(sel_bank) >= BANK_NUM);

  // Decode the selected bank index into a one-hot select.
  always_comb begin
    sel_psel = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      sel_psel[b] = (int'(sel_bank) == b);
    end
  end

  // A TIMEOUT of 0 disables the limit, so the counter is never consulted.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    last_d    = last_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          gnt_d    = sel_oh;
          last_d   = sel_idx;
          pwrite_d = sel_write;
          paddr_d  = sel_addr;
          pwdata_d = sel_wdata;
          cnt_d    = '0;
          if (sel_bad) begin
            // No slave behind this index: report an error without touching the bus.
            state_d = ST_DONE;
            done_d  = sel_oh;
            err_d   = 1'b1;
            rdata_d = '0;
            psel_d  = '0;
          end else begin
            state_d = ST_SETUP;
            psel_d  = sel_psel;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ST_ACCESS: begin
        if (b_pready) begin
          // pready takes priority over a timeout that expires on the same edge.
          state_d   = ST_DONE;
          psel_d    = '0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          err_d     = 1'b0;
          rdata_d   = pwrite_q ? '0 : b_prdata;
        end else if (timeout_hit) begin
          state_d   = ST_DONE;
          psel_d    = '0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end

      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus at once and suppresses req_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      last_q    <= IDX_W'(REQ_NUM - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_gnt   = gnt_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign b_psel    = psel_q;
  assign b_penable = penable_q;
  assign b_pwrite  = pwrite_q;
  assign b_paddr   = paddr_q;
  assign b_pwdata  = pwdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter: a main instance with two banks and TIMEOUT=16,
// and a second instance with a single bank for the bad-bank path.
module tb_apb_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  // Main instance signals.
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [1:0]  req_bank = '0;
  logic [5:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_gnt;
  logic [1:0]  req_done;
  logic        req_err;
  logic [7:0]  rsp_rdata;
  logic [1:0]  b_psel;
  logic        b_penable;
  logic        b_pwrite;
  logic [2:0]  b_paddr;
  logic [7:0]  b_pwdata;
  logic        b_pready = 1'b0;
  logic [7:0]  b_prdata = '0;
  logic [1:0]  dbg_state;

  // Single-bank instance signals.
  logic [1:0]  d2_req_valid = '0;
  logic [1:0]  d2_req_write = '0;
  logic [1:0]  d2_req_bank = '0;
  logic [5:0]  d2_req_addr = '0;
  logic [15:0] d2_req_wdata = '0;
  logic [1:0]  d2_req_gnt;
  logic [1:0]  d2_req_done;
  logic        d2_req_err;
  logic [7:0]  d2_rsp_rdata;
  logic [0:0]  d2_b_psel;
  logic        d2_b_penable;
  logic        d2_b_pwrite;
  logic [2:0]  d2_b_paddr;
  logic [7:0]  d2_b_pwdata;
  logic        d2_b_pready = 1'b1;
  logic [7:0]  d2_b_prdata = 8'h00;
  logic [1:0]  d2_dbg_state;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {expected req_done vector, req_err, rsp_rdata}.
  logic [10:0] exp_q[$];
  logic [10:0] exp_e;
  logic [10:0] got_e;
  logic [1:0]  prev_done = '0;
  logic        d2_psel_seen = 1'b0;

  apb_bus_arbiter #(
    .REQ_NUM(2), .BANK_NUM(2), .BANK_IDX_W(1),
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_bank(req_bank),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata),
    .b_psel(b_psel), .b_penable(b_penable), .b_pwrite(b_pwrite),
    .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pready(b_pready), .b_prdata(b_prdata),
    .dbg_state(dbg_state)
  );

  apb_bus_arbiter #(
    .REQ_NUM(2), .BANK_NUM(1), .BANK_IDX_W(1),
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(16)
  ) dut_one_bank (
    .clk(clk), .resetn(resetn),
    .req_valid(d2_req_valid), .req_write(d2_req_write), .req_bank(d2_req_bank),
    .req_addr(d2_req_addr), .req_wdata(d2_req_wdata),
    .req_gnt(d2_req_gnt), .req_done(d2_req_done), .req_err(d2_req_err), .rsp_rdata(d2_rsp_rdata),
    .b_psel(d2_b_psel), .b_penable(d2_b_penable), .b_pwrite(d2_b_pwrite),
    .b_paddr(d2_b_paddr), .b_pwdata(d2_b_pwdata), .b_pready(d2_b_pready), .b_prdata(d2_b_prdata),
    .dbg_state(d2_dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Scoreboard: every req_done pulse of the main instance pops one expected entry.
  always @(negedge clk) begin
    if (resetn && req_done !== 2'b00) begin
      checks++;
      if (prev_done !== 2'b00) begin
        errors++;
        $display("FAIL sb_done_width: req_done=%b high two cycles in a row", req_done);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: req_done=%b with empty expected queue", req_done);
      end else begin
        exp_e = exp_q.pop_front();
        got_e = {req_done, req_err, rsp_rdata};
        if (got_e !== exp_e) begin
          errors++;
          $display("FAIL sb_done: got done=%b err=%b rdata=%h, want done=%b err=%b rdata=%h",
                   got_e[10:9], got_e[8], got_e[7:0], exp_e[10:9], exp_e[8], exp_e[7:0]);
        end
      end
    end
    prev_done = resetn ? req_done : 2'b00;
    if (resetn && d2_b_psel !== 1'b0) d2_psel_seen = 1'b1;
  end

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_gnt, req_done, req_err, rsp_rdata, b_psel, b_penable, b_pwrite, b_paddr, b_pwdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b rdata=%h psel=%b pen=%b pw=%b addr=%h wd=%h, want all 0",
               req_gnt, req_done, req_err, rsp_rdata, b_psel, b_penable, b_pwrite, b_paddr, b_pwdata);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d want 0", dbg_state);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || req_gnt !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_req: state=%0d gnt=%b, want 0 and 00", dbg_state, req_gnt);
    end
  endtask

  task automatic test_single_write();
    req_write    = 2'b01;
    req_bank[0]  = 1'b1;
    req_addr[2:0] = 3'd5;
    req_wdata[7:0] = 8'hA5;
    b_pready = 1'b1;
    b_prdata = 8'hEE;
    req_valid = 2'b01;
    exp_q.push_back({2'b01, 1'b0, 8'h00});
    @(negedge clk);
    checks++;
    if ({b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, req_gnt} !== {2'b10, 1'b0, 1'b1, 3'd5, 8'hA5, 2'b01}) begin
      errors++;
      $display("FAIL wr_setup: psel=%b pen=%b pw=%b addr=%0d wd=%h gnt=%b, want 10 0 1 5 a5 01",
               b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, req_gnt);
    end
    @(negedge clk);
    checks++;
    if ({b_psel, b_penable, b_paddr, b_pwdata} !== {2'b10, 1'b1, 3'd5, 8'hA5}) begin
      errors++;
      $display("FAIL wr_access: psel=%b pen=%b addr=%0d wd=%h, want 10 1 5 a5",
               b_psel, b_penable, b_paddr, b_pwdata);
    end
    @(negedge clk);
    checks++;
    if ({req_done, req_err, b_psel, b_penable} !== {2'b01, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL wr_done: done=%b err=%b psel=%b pen=%b, want 01 0 00 0",
               req_done, req_err, b_psel, b_penable);
    end
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({req_gnt, req_done, dbg_state} !== {2'b00, 2'b00, 2'd0}) begin
      errors++;
      $display("FAIL wr_idle: gnt=%b done=%b state=%0d, want 00 00 0", req_gnt, req_done, dbg_state);
    end
  endtask

  task automatic test_wait_read();
    int pen_cnt = 0;
    logic unstable = 1'b0;
    req_write[1]  = 1'b0;
    req_bank[1]   = 1'b0;
    req_addr[5:3] = 3'd3;
    b_pready = 1'b0;
    b_prdata = 8'h3C;
    req_valid = 2'b10;
    exp_q.push_back({2'b10, 1'b0, 8'h3C});
    @(negedge clk);
    checks++;
    if ({b_psel, b_penable, b_pwrite, b_paddr, req_gnt} !== {2'b01, 1'b0, 1'b0, 3'd3, 2'b10}) begin
      errors++;
      $display("FAIL rd_setup: psel=%b pen=%b pw=%b addr=%0d gnt=%b, want 01 0 0 3 10",
               b_psel, b_penable, b_pwrite, b_paddr, req_gnt);
    end
    for (int i = 0; i < 40 && req_done === 2'b00; i++) begin
      @(negedge clk);
      if (b_penable) begin
        pen_cnt++;
        if (b_psel !== 2'b01 || b_paddr !== 3'd3) unstable = 1'b1;
        if (pen_cnt == 4) b_pready = 1'b1;
      end
    end
    checks++;
    if (pen_cnt != 4 || unstable || req_done !== 2'b10 || rsp_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL rd_wait: penable cycles=%0d unstable=%b done=%b rdata=%h, want 4 0 10 3c",
               pen_cnt, unstable, req_done, rsp_rdata);
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n_done = 0;
    logic [1:0] exp_g = 2'b01;
    logic after_done = 1'b0;
    req_write = 2'b01;
    req_bank  = 2'b01;
    req_addr  = {3'd2, 3'd4};
    req_wdata = {8'h00, 8'h11};
    b_pready = 1'b1;
    b_prdata = 8'h5A;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({2'b01, 1'b0, 8'h00});
      exp_q.push_back({2'b10, 1'b0, 8'h5A});
    end
    req_valid = 2'b11;
    for (int i = 0; i < 40 && n_done < 4; i++) begin
      @(negedge clk);
      if (after_done) begin
        checks++;
        if (req_gnt !== 2'b00) begin
          errors++;
          $display("FAIL rr_gap: gnt=%b in cycle after done, want 00", req_gnt);
        end
      end
      after_done = 1'b0;
      if (b_psel !== 2'b00 && !b_penable) begin
        checks++;
        if (req_gnt !== exp_g) begin
          errors++;
          $display("FAIL rr_order: gnt=%b want %b", req_gnt, exp_g);
        end
        exp_g = ~exp_g;
      end
      if (req_done !== 2'b00) begin
        n_done++;
        after_done = 1'b1;
        if (n_done == 4) req_valid = 2'b00;
      end
    end
    checks++;
    if (n_done != 4) begin
      errors++;
      $display("FAIL rr_count: transfers=%0d want 4", n_done);
    end
    @(negedge clk);
  endtask

  task automatic run_timeout(input logic [1:0] who, input logic [2:0] addr,
                             input int ready_at, input logic [7:0] prdata,
                             input logic exp_err, input logic [7:0] exp_rdata);
    int pen_cnt = 0;
    req_write = 2'b00;
    req_bank  = 2'b10;
    req_addr  = {addr, addr};
    b_pready = 1'b0;
    b_prdata = prdata;
    req_valid = who;
    exp_q.push_back({who, exp_err, exp_rdata});
    for (int i = 0; i < 60 && req_done === 2'b00; i++) begin
      @(negedge clk);
      if (b_penable) begin
        pen_cnt++;
        if (pen_cnt == ready_at) b_pready = 1'b1;
      end
    end
    checks++;
    if (pen_cnt != 16 || req_done !== who || req_err !== exp_err || rsp_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL timeout_%0d: penable cycles=%0d done=%b err=%b rdata=%h, want 16 %b %b %h",
               ready_at, pen_cnt, req_done, req_err, rsp_rdata, who, exp_err, exp_rdata);
    end
    req_valid = 2'b00;
    b_pready = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_psel, b_penable, req_gnt} !== 5'b0) begin
      errors++;
      $display("FAIL timeout_idle: psel=%b pen=%b gnt=%b, want 00 0 00", b_psel, b_penable, req_gnt);
    end
  endtask

  task automatic test_timeout();
    // Slave never ready: sixteen ACCESS cycles then an error with zero data.
    run_timeout(2'b01, 3'd2, 0, 8'hFF, 1'b1, 8'h00);
    // Ready arrives on the sixteenth ACCESS cycle: the data wins over the timeout.
    run_timeout(2'b10, 3'd6, 16, 8'h96, 1'b0, 8'h96);
  endtask

  task automatic test_bad_bank();
    d2_req_write = 2'b01;
    d2_req_bank  = 2'b01;
    d2_req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if ({d2_req_done, d2_req_err, d2_rsp_rdata, d2_b_psel, d2_req_gnt} !== {2'b01, 1'b1, 8'h00, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL bad_bank: done=%b err=%b rdata=%h psel=%b gnt=%b, want 01 1 00 0 01",
               d2_req_done, d2_req_err, d2_rsp_rdata, d2_b_psel, d2_req_gnt);
    end
    d2_req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({d2_req_done, d2_req_gnt, d2_req_err} !== {2'b00, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL bad_bank_after: done=%b gnt=%b err=%b, want 00 00 1 (held)",
               d2_req_done, d2_req_gnt, d2_req_err);
    end
  endtask

  task automatic test_reset_mid();
    req_write = 2'b00;
    req_bank  = 2'b11;
    req_addr  = {3'd7, 3'd1};
    b_pready = 1'b0;
    req_valid = 2'b01;
    for (int i = 0; i < 10 && !b_penable; i++) @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if ({b_psel, b_penable, req_gnt, dbg_state} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid: psel=%b pen=%b gnt=%b state=%0d, want 00 0 00 0",
               b_psel, b_penable, req_gnt, dbg_state);
    end
    req_valid = 2'b10;
    b_pready = 1'b1;
    b_prdata = 8'hC3;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (req_done !== 2'b00) begin
        errors++;
        $display("FAIL rst_no_done: done=%b during reset, want 00", req_done);
      end
    end
    exp_q.push_back({2'b10, 1'b0, 8'hC3});
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_gnt, b_psel, b_paddr} !== {2'b10, 2'b10, 3'd7}) begin
      errors++;
      $display("FAIL rst_regrant: gnt=%b psel=%b addr=%0d, want 10 10 7", req_gnt, b_psel, b_paddr);
    end
    for (int i = 0; i < 10 && req_done === 2'b00; i++) @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wait_read();
    test_round_robin();
    test_timeout();
    test_bad_bank();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected completions never seen, want 0", exp_q.size());
    end
    checks++;
    if (d2_psel_seen !== 1'b0) begin
      errors++;
      $display("FAIL bad_bank_psel: psel seen=%b on single-bank instance, want 0", d2_psel_seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
